// File: rtl/io_bus_master.sv
// io_bus_master: single-command IO-bus initiator with wait-state handling and status reporting.
// Defining IO_MASTER_TIMEOUT_EN adds the busy-wait counter and timeout abort (status 11).
module io_bus_master #(
  parameter int CTimeout = 64
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        AReqStart,
  input  logic        AReqWr,
  input  logic [1:0]  AReqSize,
  input  logic [15:0] AReqAddr,
  input  logic [63:0] AReqData,
  output logic        AReqReady,
  output logic        ARespValid,
  output logic [63:0] ARespData,
  output logic [1:0]  ARespErr,
  output logic [15:0] AIoAddr,
  output logic [63:0] AIoMosi,
  output logic [3:0]  AIoWrSize,
  output logic [3:0]  AIoRdSize,
  input  logic [63:0] AIoMiso,
  input  logic        AIoAddrAck,
  input  logic        AIoAddrErr,
  input  logic        AIoBusy
);
  // state  | meaning
  // Idle   | ready for a command, bus quiet
  // Access | bus driven, waiting for AIoBusy to drop
  // Done   | one-cycle completion pulse, bus quiet
  typedef enum logic [1:0] {Idle, Access, Done} stateT;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrAddr    = 2'b01;
  localparam logic [1:0] ErrNoAck   = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  stateT       state, stateNxt;
  logic        wrQ, wrNxt;
  logic [1:0]  sizeQ, sizeNxt;
  logic        readyNxt, validNxt;
  logic [63:0] respDataNxt;
  logic [1:0]  respErrNxt;
  logic [15:0] addrNxt;
  logic [63:0] mosiNxt;
  logic [3:0]  wrSizeNxt, rdSizeNxt;
  logic [63:0] sizeMask;
  logic        timedOut;

  always_comb begin
    sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (sizeQ)
      2'd0:    sizeMask = 64'h0000_0000_0000_00FF;
      2'd1:    sizeMask = 64'h0000_0000_0000_FFFF;
      2'd2:    sizeMask = 64'h0000_0000_FFFF_FFFF;
      default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

`ifdef IO_MASTER_TIMEOUT_EN
  // Down-counter loaded with the allowance; abort once it is spent and the responder is still busy.
  logic [7:0] waitCnt, waitCntNxt;

  assign timedOut = (waitCnt == 8'd0);

  always_comb begin
    waitCntNxt = waitCnt;
    if (state == Idle && AReqStart)
      waitCntNxt = 8'(CTimeout);
    else if (state == Access && AIoBusy && !timedOut)
      waitCntNxt = waitCnt - 8'd1;
  end

  always_ff @(posedge AClkH) begin
    if (!AResetHN)
      waitCnt <= 8'd0;
    else if (AClkHEn)
      waitCnt <= waitCntNxt;
  end
`else
  assign timedOut = 1'b0;
`endif

  always_comb begin
    stateNxt    = state;
    readyNxt    = 1'b0;
    validNxt    = 1'b0;
    respDataNxt = ARespData;
    respErrNxt  = ARespErr;
    addrNxt     = AIoAddr;
    mosiNxt     = AIoMosi;
    wrSizeNxt   = AIoWrSize;
    rdSizeNxt   = AIoRdSize;
    wrNxt       = wrQ;
    sizeNxt     = sizeQ;
    case (state)
      Idle: begin
        readyNxt = 1'b1;
        if (AReqStart) begin
          stateNxt  = Access;
          readyNxt  = 1'b0;
          wrNxt     = AReqWr;
          sizeNxt   = AReqSize;
          addrNxt   = AReqAddr;
          mosiNxt   = AReqData;
          wrSizeNxt = AReqWr ? (4'b0001 << AReqSize) : 4'b0000;
          rdSizeNxt = AReqWr ? 4'b0000 : (4'b0001 << AReqSize);
        end
      end
      Access: begin
        if (!AIoBusy || timedOut) begin
          stateNxt  = Done;
          validNxt  = 1'b1;
          addrNxt   = 16'd0;
          mosiNxt   = 64'd0;
          wrSizeNxt = 4'd0;
          rdSizeNxt = 4'd0;
          respDataNxt = 64'd0;
          if (AIoBusy)
            respErrNxt = ErrTimeout;
          else if (AIoAddrErr)
            respErrNxt = ErrAddr;
          else if (!AIoAddrAck)
            respErrNxt = ErrNoAck;
          else begin
            respErrNxt = ErrOk;
            if (!wrQ)
              respDataNxt = AIoMiso & sizeMask;
          end
        end
      end
      Done: begin
        stateNxt = Idle;
        readyNxt = 1'b1;
      end
      default: stateNxt = Idle;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      state      <= Idle;
      wrQ        <= 1'b0;
      sizeQ      <= 2'd0;
      AReqReady  <= 1'b1;
      ARespValid <= 1'b0;
      ARespData  <= 64'd0;
      ARespErr   <= ErrOk;
      AIoAddr    <= 16'd0;
      AIoMosi    <= 64'd0;
      AIoWrSize  <= 4'd0;
      AIoRdSize  <= 4'd0;
    end else if (AClkHEn) begin
      state      <= stateNxt;
      wrQ        <= wrNxt;
      sizeQ      <= sizeNxt;
      AReqReady  <= readyNxt;
      ARespValid <= validNxt;
      ARespData  <= respDataNxt;
      ARespErr   <= respErrNxt;
      AIoAddr    <= addrNxt;
      AIoMosi    <= mosiNxt;
      AIoWrSize  <= wrSizeNxt;
      AIoRdSize  <= rdSizeNxt;
    end
  end

endmodule
